// File: rtl/serial_sub_if.sv
// serial_sub_if: start/ready handshake, operands and result bus for serial_sub.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
// Handshake: a/b/bin are taken on the rising edge where start=1 and ready=1.
// done is high for exactly one cycle when diff/bout (and ovf) hold a new result.
// A start while ready=0 is dropped, not queued.
interface serial_sub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif
   // Debug view of the controller state (0=IDLE, 1=SHIFT, 2=DONE)
   logic [1:0]       dbg_state;

`ifdef SERIAL_SUB_OVF_EN
   modport master (output start, a, b, bin,
                   input  ready, busy, done, diff, bout, ovf, dbg_state);
   modport slave  (input  start, a, b, bin,
                   output ready, busy, done, diff, bout, ovf, dbg_state);
`else
   modport master (output start, a, b, bin,
                   input  ready, busy, done, diff, bout, dbg_state);
   modport slave  (input  start, a, b, bin,
                   output ready, busy, done, diff, bout, dbg_state);
`endif
endinterface

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, diff = a - b - bin, one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flop.
// Optional feature macro: SERIAL_SUB_OVF_EN adds a signed-overflow flag (ovf).
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   serial_sub_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sd;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb;
   logic             b_msb;
   logic             ovf_q;
`endif

   logic             d_bit;
   logic             br_next;
   logic [WIDTH-1:0] sd_next;

   // Full-subtractor cell on the current LSBs; new bit enters the top of sd
   assign d_bit   = sa[0] ^ sb[0] ^ br;
   assign br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
   assign sd_next = (sd >> 1) | ({{(WIDTH-1){1'b0}}, d_bit} << (WIDTH - 1));

   // Controller, datapath and registered outputs; diff/bout only move on completion
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sa      <= '0;
         sb      <= '0;
         sd      <= '0;
         br      <= 1'b0;
         cnt     <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb   <= 1'b0;
         b_msb   <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sa      <= bus.a;
                  sb      <= bus.b;
                  sd      <= '0;
                  br      <= bus.bin;
                  cnt     <= '0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                  a_msb   <= bus.a[WIDTH-1];
                  b_msb   <= bus.b[WIDTH-1];
`endif
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sd  <= sd_next;
               br  <= br_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  diff_q <= sd_next;
                  bout_q <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                  ovf_q  <= (a_msb != b_msb) & (d_bit != a_msb);
`endif
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready     = ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.diff      = diff_q;
   assign bus.bout      = bout_q;
   assign bus.dbg_state = state;
`ifdef SERIAL_SUB_OVF_EN
   assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: self-checking bench for serial_sub (WIDTH=8).
// Expected results come from wide unsigned/signed arithmetic and sit in a
// queue until the DUT raises done.
module tb_serial_sub;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_sub_if #(.WIDTH(W)) bus ();

   serial_sub #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec  = 0;
   int n_fail = 0;
   logic [W+1:0] exp_q[$];   // {ovf, bout, diff}

   // Reference model: wide subtraction for diff/bout, signed range test for ovf
   task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      logic [W:0] full;
      int         sr;
      logic       ov;
      full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      sr   = int'($signed(a)) - int'($signed(b)) - int'(bin);
      ov   = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
      exp_q.push_back({ov, full[W], full[W-1:0]});
   endtask

   // Present one start pulse at a falling edge; returns after the accepting edge
   task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = W'($urandom_range(0, 255));
      bus.b     = W'($urandom_range(0, 255));
      bus.bin   = 1'($urandom_range(0, 1));
   endtask

   // Step falling edges until done is seen or the budget runs out
   task automatic wait_done(output int lat, output bit seen);
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 4 * W && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (bus.done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({bus.ready, bus.busy, bus.done, bus.bout} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_flags: got rdy/busy/done/bout=%b required 1000",
                  {bus.ready, bus.busy, bus.done, bus.bout});
      end
      n_vec++;
      if (bus.diff !== '0) begin
         n_fail++;
         $display("FAIL reset_diff: got %h required 00", bus.diff);
      end
`ifdef SERIAL_SUB_OVF_EN
      n_vec++;
      if (bus.ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ovf: got %b required 0", bus.ovf);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [W-1:0] ta[4];
      logic [W-1:0] tb_[4];
      logic         tc[4];
      logic [W+1:0] e;
      int           lat;
      bit           seen;
      ta  = '{8'h05, 8'h03, 8'h00, 8'hFF};
      tb_ = '{8'h03, 8'h05, 8'h00, 8'hFF};
      tc  = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         push_exp(ta[i], tb_[i], tc[i]);
         drive_start(ta[i], tb_[i], tc[i]);
         n_vec++;
         if ({bus.ready, bus.busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_shift_flags[%0d]: got rdy/busy=%b required 01", i, {bus.ready, bus.busy});
         end
         wait_done(lat, seen);
         e = exp_q.pop_front();
         n_vec++;
         if (!seen) begin
            n_fail++;
            $display("FAIL basic_timeout[%0d]: got no done required done", i);
         end else begin
            if (lat != W) begin
               n_fail++;
               $display("FAIL basic_latency[%0d]: got %0d required %0d", i, lat, W);
            end
            n_vec++;
            if ({bus.bout, bus.diff} !== e[W:0]) begin
               n_fail++;
               $display("FAIL basic_result[%0d]: got bout/diff=%b/%h required %b/%h",
                        i, bus.bout, bus.diff, e[W], e[W-1:0]);
            end
            @(negedge clk);
            n_vec++;
            if ({bus.done, bus.ready} !== 2'b01) begin
               n_fail++;
               $display("FAIL basic_after_done[%0d]: got done/rdy=%b required 01", i, {bus.done, bus.ready});
            end
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [W+1:0] e;
      int           lat;
      int           pulses;
      int           busy_seen;
      bit           seen;
      push_exp(8'h40, 8'h10, 1'b0);
      drive_start(8'h40, 8'h10, 1'b0);
      repeat (2) @(negedge clk);
      // third SHIFT cycle: stray start must be dropped
      bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.bin = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat, seen);
      e = exp_q.pop_front();
      n_vec++;
      if (!seen || lat + 3 != W) begin
         n_fail++;
         $display("FAIL ignore_latency: got seen=%0d lat=%0d required 1 %0d", seen, lat + 3, W);
      end
      n_vec++;
      if ({bus.bout, bus.diff} !== e[W:0]) begin
         n_fail++;
         $display("FAIL ignore_result: got bout/diff=%b/%h required %b/%h", bus.bout, bus.diff, e[W], e[W-1:0]);
      end
      // DONE cycle: another stray start
      bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01;
      @(negedge clk);
      bus.start = 1'b0;
      n_vec++;
      if ({bus.done, bus.ready, bus.busy} !== 3'b010) begin
         n_fail++;
         $display("FAIL ignore_idle: got done/rdy/busy=%b required 010", {bus.done, bus.ready, bus.busy});
      end
      pulses = 0;
      busy_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done === 1'b1) pulses++;
         if (bus.busy === 1'b1) busy_seen++;
      end
      n_vec++;
      if (pulses != 0 || busy_seen != 0 || bus.diff !== 8'h30) begin
         n_fail++;
         $display("FAIL ignore_no_restart: got done=%0d busy=%0d diff=%h required 0 0 30", pulses, busy_seen, bus.diff);
      end
   endtask

   task automatic test_abort();
      logic [W+1:0] e;
      int           lat;
      int           pulses;
      bit           seen;
      drive_start(8'hAA, 8'h55, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if ({bus.ready, bus.busy, bus.done, bus.bout} !== 4'b1000 || bus.diff !== 8'h00) begin
         n_fail++;
         $display("FAIL abort_state: got rdy/busy/done/bout=%b diff=%h required 1000 00",
                  {bus.ready, bus.busy, bus.done, bus.bout}, bus.diff);
      end
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done === 1'b1) pulses++;
      end
      n_vec++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d pulses required 0", pulses);
      end
      push_exp(8'h10, 8'h01, 1'b0);
      drive_start(8'h10, 8'h01, 1'b0);
      wait_done(lat, seen);
      e = exp_q.pop_front();
      n_vec++;
      if (!seen || {bus.bout, bus.diff} !== e[W:0]) begin
         n_fail++;
         $display("FAIL abort_restart: got seen=%0d bout/diff=%b/%h required 1 %b/%h",
                  seen, bus.bout, bus.diff, e[W], e[W-1:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [W+1:0] e;
      int           lat;
      int           unstable;
      bit           seen;
      push_exp(8'h33, 8'h11, 1'b0);
      drive_start(8'h33, 8'h11, 1'b0);
      wait_done(lat, seen);
      e = exp_q.pop_front();
      n_vec++;
      if (!seen || {bus.bout, bus.diff} !== e[W:0]) begin
         n_fail++;
         $display("FAIL b2b_first: got seen=%0d bout/diff=%b/%h required 1 %b/%h",
                  seen, bus.bout, bus.diff, e[W], e[W-1:0]);
      end
      @(negedge clk);
      n_vec++;
      if (bus.ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_ready: got %b required 1", bus.ready);
      end
      push_exp(8'h80, 8'h01, 1'b0);
      drive_start(8'h80, 8'h01, 1'b0);
      n_vec++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept: got busy=%b required 1", bus.busy);
      end
      unstable = 0;
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 4 * W && !seen; i++) begin
         if (bus.diff !== 8'h22) unstable++;
         @(negedge clk);
         lat++;
         if (bus.done === 1'b1) seen = 1'b1;
      end
      n_vec++;
      if (unstable != 0) begin
         n_fail++;
         $display("FAIL b2b_hold: got %0d changed cycles required 0", unstable);
      end
      e = exp_q.pop_front();
      n_vec++;
      if (!seen || lat != W || {bus.bout, bus.diff} !== e[W:0]) begin
         n_fail++;
         $display("FAIL b2b_second: got seen=%0d lat=%0d bout/diff=%b/%h required 1 %0d %b/%h",
                  seen, lat, bus.bout, bus.diff, W, e[W], e[W-1:0]);
      end
      @(negedge clk);
   endtask

`ifdef SERIAL_SUB_OVF_EN
   task automatic test_ovf();
      logic [W-1:0] ta[3];
      logic [W-1:0] tb_[3];
      logic [W+1:0] e;
      int           lat;
      bit           seen;
      ta  = '{8'h80, 8'h7F, 8'h10};
      tb_ = '{8'h01, 8'hFF, 8'h01};
      for (int i = 0; i < 3; i++) begin
         push_exp(ta[i], tb_[i], 1'b0);
         drive_start(ta[i], tb_[i], 1'b0);
         wait_done(lat, seen);
         e = exp_q.pop_front();
         n_vec++;
         if (!seen || {bus.ovf, bus.bout, bus.diff} !== e) begin
            n_fail++;
            $display("FAIL ovf[%0d]: got seen=%0d ovf/bout/diff=%b/%b/%h required 1 %b/%b/%h",
                     i, seen, bus.ovf, bus.bout, bus.diff, e[W+1], e[W], e[W-1:0]);
         end
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_ignore_start();
      test_abort();
      test_back_to_back();
`ifdef SERIAL_SUB_OVF_EN
      test_ovf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial subtractor; the inverse-direction counterpart of the team's combinational full-adder datapath.
- Loads two WIDTH-bit operands and a borrow-in, then computes a - b - bin LSB-first through a single full-subtractor cell with a borrow flip-flop, one bit per clock.
- Used where area matters more than latency. Sits behind a start/ready handshake and reports completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new subtraction; honoured only when ready=1
- a  input  WIDTH  minuend; sampled on the accepting edge
- b  input  WIDTH  subtrahend; sampled on the accepting edge
- bin  input  1  borrow-in; sampled on the accepting edge
- ready  output  1  high in IDLE only
- busy  output  1  high while bits are being shifted
- done  output  1  one-cycle pulse when the result is valid
- diff  output  WIDTH  result a - b - bin mod 2^WIDTH
- bout  output  1  final borrow-out; 1 iff a < b + bin (unsigned)

Behaviour:
- Reset: sampled on the clk edge while rst=1. State goes to IDLE and values are: ready=1, busy=0, done=0, diff=0, bout=0, internal borrow=0, bit counter=0, shift registers=0.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - ready=1.
  - On an edge with start=1: load a, b, diff shift registers; borrow<=bin; counter<=0; go to SHIFT. This is edge E0.
  - start=0: stay in IDLE.
- SHIFT:
  - ready=0, busy=1.
  - Each edge processes the LSB of the shifted a/b: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d enters the MSB of the diff shift register; all registers shift right by one; counter increments.
  - Edge E(WIDTH), i.e. when counter = WIDTH-1 before the edge: final bit processed; diff holds the full result, bout <= br_next; go to DONE.
- DONE:
  - One cycle only: done=1, busy=0, ready=0. Next edge returns to IDLE with done=0.
- Latency: done is high in the cycle after edge E(WIDTH). The next start can be accepted at edge E(WIDTH+2) at the earliest.
- diff and bout change only at the end of a computation or on reset. They hold their values through IDLE until the next result completes. Intermediate shift contents are never visible on diff.
- start while ready=0 (SHIFT or DONE) is ignored, not queued. a, b and bin are don't-care outside the accepting edge.
- rst=1 mid-operation aborts immediately: IDLE, all outputs at reset values. No done pulse is issued for the aborted operation.
- rst and start on the same edge: reset wins.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - Extra output port ovf (1 bit): two's-complement signed overflow of a - b - bin.
  - ovf = (a_msb != b_msb) & (diff_msb != a_msb), computed from the loaded operand MSBs and the final diff MSB.
  - Updated on the same edge as bout; reset value 0; held like diff.
- When not defined: no ovf port and no associated logic. All other behaviour is identical.

Test Plan:
- WIDTH=8, rst high 2 cycles then start with a=0x05, b=0x03, bin=0 -> done pulses exactly once, in the cycle after the 8th shift edge; diff=0x02, bout=0; ready returns 1 the following cycle.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0.
- Start a=0x40, b=0x10; pulse start with a=0x01, b=0x01 on the 3rd SHIFT cycle and again on the DONE cycle -> both ignored; result diff=0x30, bout=0; exactly one done pulse.
- Start a=0xAA, b=0x55; assert rst on the 4th SHIFT cycle -> next cycle ready=1, busy=0, done=0, diff=0x00, bout=0, and no done pulse follows. A new start with a=0x10, b=0x01 gives diff=0x0F.
- Back-to-back operations: start asserted on the first IDLE cycle after done, with a=0x80, b=0x01 -> accepted; diff=0x7F, bout=0. The previous diff stays stable until the new done.
- With SERIAL_SUB_OVF_EN defined: a=0x80, b=0x01 -> ovf=1; a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1; a=0x10, b=0x01 -> ovf=0. Without the macro, the bench compiles with no ovf port.
